operand_sel_pipe: RTL and testbench

Parametrised operand-select stage for the pipelined datapath: picks one of NSRC WIDTH-bit sources (register file, extender output, forwarded results, ...) and registers it into the next pipeline stage. It replaces the fixed two-input combinational operand select. It adds a registered output, stall hold, flush, in-stall forwarding refresh, out-of-range select detection and a saturating stall-cycle counter. It sits at the D→E boundary, feeding the ALU B operand.

---
 rtl/operand_sel_pipe.sv | 103 ++++++++++
 tb/tb_operand_sel_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_sel_pipe.sv
// Operand select for the D->E boundary: muxes one of NSRC sources into a pipeline register.
// Latency: one cycle, and every output comes straight from a flop.
// Backpressure: stall holds the operand (refresh re-reads the held index); flush empties the stage.
module operand_sel_pipe #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2,
    parameter int CNTW  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [SELW-1:0]       src_sel,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  refresh,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic [SELW-1:0]       out_sel,
    output logic                  sel_err,
    output logic [CNTW-1:0]       stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t            state_q;
    logic [WIDTH-1:0]  data_q;
    logic              valid_q;
    logic [SELW-1:0]   sel_q;
    logic              err_q;
    logic [CNTW-1:0]   cnt_q;

    logic [WIDTH-1:0]  load_data_d;
    logic [WIDTH-1:0]  refresh_data_d;
    logic              sel_in_range_d;
    logic [CNTW-1:0]   cnt_inc_d;

    // Two source muxes: one on the incoming index for loads, one on the held index
    // for forwarding refresh. An out-of-range index matches no source and yields zero.
    always_comb begin
        load_data_d    = '0;
        refresh_data_d = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (src_sel == SELW'(k)) begin
                load_data_d = src_data[k*WIDTH +: WIDTH];
            end
            if (sel_q == SELW'(k)) begin
                refresh_data_d = src_data[k*WIDTH +: WIDTH];
            end
        end
        sel_in_range_d = (32'(src_sel) < NSRC);
        cnt_inc_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Stage FSM with registered outputs; priority reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (stall) begin
            // An empty stage simply holds; a held operand keeps its index and error flag.
            if (state_q != ST_EMPTY) begin
                if (refresh) begin
                    data_q <= refresh_data_d;
                end
                cnt_q   <= cnt_inc_d;
                state_q <= ST_HELD;
            end
        end else if (in_valid) begin
            state_q <= ST_FULL;
            data_q  <= load_data_d;
            valid_q <= 1'b1;
            sel_q   <= src_sel;
            err_q   <= ~sel_in_range_d;
            cnt_q   <= '0;
        end else begin
            // Bubble: out_sel keeps its last captured value.
            state_q <= ST_EMPTY;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sel   = sel_q;
    assign sel_err   = err_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Bench for operand_sel_pipe: one instance at NSRC=4/CNTW=4, one at NSRC=3/CNTW=2, same stimulus.
// Expected outputs are queued when a cycle is driven and popped after the clock edge.
module tb_operand_sel_pipe;

    localparam logic [31:0] A = 32'h11111111;
    localparam logic [31:0] B = 32'h22222222;
    localparam logic [31:0] C = 32'h33333333;
    localparam logic [31:0] D = 32'h44444444;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
        logic [1:0]  sel;
        logic        err;
        logic [3:0]  cnt;
    } obs_t;

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic        stl;
        logic        rfr;
        logic        fls;
        logic [1:0]  sel;
        logic [31:0] w1;
        obs_t        ea;
        obs_t        eb;
    } step_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] src_data;
    logic [1:0]   src_sel;
    logic         in_valid, stall, refresh, flush;

    logic [31:0]  a_data, b_data;
    logic         a_valid, b_valid, a_err, b_err;
    logic [1:0]   a_sel, b_sel;
    logic [3:0]   a_cnt;
    logic [1:0]   b_cnt;

    int vectors     = 0;
    int miscompares = 0;

    obs_t qa[$];
    obs_t qb[$];

    always #5 clk = ~clk;

    operand_sel_pipe #(.WIDTH(32), .NSRC(4), .SELW(2), .CNTW(4)) dut_a (
        .clk(clk), .reset(reset), .src_data(src_data), .src_sel(src_sel),
        .in_valid(in_valid), .stall(stall), .refresh(refresh), .flush(flush),
        .out_data(a_data), .out_valid(a_valid), .out_sel(a_sel), .sel_err(a_err),
        .stall_cnt(a_cnt)
    );

    operand_sel_pipe #(.WIDTH(32), .NSRC(3), .SELW(2), .CNTW(2)) dut_b (
        .clk(clk), .reset(reset), .src_data(src_data[95:0]), .src_sel(src_sel),
        .in_valid(in_valid), .stall(stall), .refresh(refresh), .flush(flush),
        .out_data(b_data), .out_valid(b_valid), .out_sel(b_sel), .sel_err(b_err),
        .stall_cnt(b_cnt)
    );

    function automatic obs_t mk(logic [31:0] d, logic v, logic [1:0] s, logic e, logic [3:0] c);
        obs_t o;
        o.data = d; o.valid = v; o.sel = s; o.err = e; o.cnt = c;
        return o;
    endfunction

    function automatic step_t mkstep(logic rst, logic vld, logic stl, logic rfr, logic fls,
                                     logic [1:0] sel, logic [31:0] w1, obs_t ea, obs_t eb);
        step_t s;
        s.rst = rst; s.vld = vld; s.stl = stl; s.rfr = rfr; s.fls = fls;
        s.sel = sel; s.w1 = w1; s.ea = ea; s.eb = eb;
        return s;
    endfunction

    task automatic drive(input step_t s);
        reset    = s.rst;
        in_valid = s.vld;
        stall    = s.stl;
        refresh  = s.rfr;
        flush    = s.fls;
        src_sel  = s.sel;
        src_data = {D, C, s.w1, A};
        qa.push_back(s.ea);
        qb.push_back(s.eb);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t s[$];
        obs_t z = mk(0, 0, 0, 0, 0);
        obs_t ea, eb, oa, ob;
        s.push_back(mkstep(1, 1, 0, 0, 0, 2, B, z, z));
        s.push_back(mkstep(1, 1, 0, 0, 0, 2, B, z, z));
        foreach (s[i]) begin
            drive(s[i]);
            cyc();
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = mk(a_data, a_valid, a_sel, a_err, a_cnt);
            ob = mk(b_data, b_valid, b_sel, b_err, {2'b00, b_cnt});
            vectors += 2;
            if (oa !== ea) begin miscompares++; $display("FAIL reset[%0d] dut_a got %h expected %h", i, oa, ea); end
            if (ob !== eb) begin miscompares++; $display("FAIL reset[%0d] dut_b got %h expected %h", i, ob, eb); end
        end
    endtask

    task automatic test_load();
        step_t s[$];
        obs_t z = mk(0, 0, 0, 0, 0);
        obs_t ea, eb, oa, ob;
        s.push_back(mkstep(0, 1, 0, 0, 0, 2, B, mk(C, 1, 2, 0, 0), mk(C, 1, 2, 0, 0)));
        s.push_back(mkstep(0, 1, 0, 1, 0, 0, B, mk(A, 1, 0, 0, 0), mk(A, 1, 0, 0, 0)));
        s.push_back(mkstep(0, 0, 0, 0, 0, 0, B, z, z));
        foreach (s[i]) begin
            drive(s[i]);
            cyc();
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = mk(a_data, a_valid, a_sel, a_err, a_cnt);
            ob = mk(b_data, b_valid, b_sel, b_err, {2'b00, b_cnt});
            vectors += 2;
            if (oa !== ea) begin miscompares++; $display("FAIL load[%0d] dut_a got %h expected %h", i, oa, ea); end
            if (ob !== eb) begin miscompares++; $display("FAIL load[%0d] dut_b got %h expected %h", i, ob, eb); end
        end
    endtask

    task automatic test_stall_refresh();
        step_t s[$];
        obs_t ea, eb, oa, ob;
        logic [31:0] nb = 32'hDEADBEEF;
        s.push_back(mkstep(0, 1, 0, 0, 0, 1, B,  mk(B, 1, 1, 0, 0), mk(B, 1, 1, 0, 0)));
        s.push_back(mkstep(0, 1, 1, 0, 0, 3, nb, mk(B, 1, 1, 0, 1), mk(B, 1, 1, 0, 1)));
        s.push_back(mkstep(0, 1, 1, 0, 0, 3, nb, mk(B, 1, 1, 0, 2), mk(B, 1, 1, 0, 2)));
        s.push_back(mkstep(0, 1, 1, 0, 0, 3, nb, mk(B, 1, 1, 0, 3), mk(B, 1, 1, 0, 3)));
        s.push_back(mkstep(0, 1, 1, 1, 0, 3, nb, mk(nb, 1, 1, 0, 4), mk(nb, 1, 1, 0, 3)));
        s.push_back(mkstep(0, 1, 0, 0, 0, 0, B,  mk(A, 1, 0, 0, 0), mk(A, 1, 0, 0, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            cyc();
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = mk(a_data, a_valid, a_sel, a_err, a_cnt);
            ob = mk(b_data, b_valid, b_sel, b_err, {2'b00, b_cnt});
            vectors += 2;
            if (oa !== ea) begin miscompares++; $display("FAIL stall_refresh[%0d] dut_a got %h expected %h", i, oa, ea); end
            if (ob !== eb) begin miscompares++; $display("FAIL stall_refresh[%0d] dut_b got %h expected %h", i, ob, eb); end
        end
    endtask

    task automatic test_flush();
        step_t s[$];
        obs_t z = mk(0, 0, 0, 0, 0);
        obs_t ea, eb, oa, ob;
        s.push_back(mkstep(0, 1, 0, 0, 0, 0, B, mk(A, 1, 0, 0, 0), mk(A, 1, 0, 0, 0)));
        s.push_back(mkstep(0, 1, 1, 0, 1, 2, B, z, z));
        s.push_back(mkstep(0, 1, 1, 1, 0, 2, B, z, z));
        s.push_back(mkstep(0, 1, 0, 0, 0, 2, B, mk(C, 1, 2, 0, 0), mk(C, 1, 2, 0, 0)));
        s.push_back(mkstep(0, 0, 0, 0, 1, 0, B, z, z));
        foreach (s[i]) begin
            drive(s[i]);
            cyc();
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = mk(a_data, a_valid, a_sel, a_err, a_cnt);
            ob = mk(b_data, b_valid, b_sel, b_err, {2'b00, b_cnt});
            vectors += 2;
            if (oa !== ea) begin miscompares++; $display("FAIL flush[%0d] dut_a got %h expected %h", i, oa, ea); end
            if (ob !== eb) begin miscompares++; $display("FAIL flush[%0d] dut_b got %h expected %h", i, ob, eb); end
        end
    endtask

    task automatic test_out_of_range();
        step_t s[$];
        obs_t ea, eb, oa, ob;
        s.push_back(mkstep(0, 1, 0, 0, 0, 3, B, mk(D, 1, 3, 0, 0), mk(0, 1, 3, 1, 0)));
        s.push_back(mkstep(0, 1, 1, 1, 0, 0, B, mk(D, 1, 3, 0, 1), mk(0, 1, 3, 1, 1)));
        s.push_back(mkstep(0, 1, 0, 0, 0, 0, B, mk(A, 1, 0, 0, 0), mk(A, 1, 0, 0, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            cyc();
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = mk(a_data, a_valid, a_sel, a_err, a_cnt);
            ob = mk(b_data, b_valid, b_sel, b_err, {2'b00, b_cnt});
            vectors += 2;
            if (oa !== ea) begin miscompares++; $display("FAIL out_of_range[%0d] dut_a got %h expected %h", i, oa, ea); end
            if (ob !== eb) begin miscompares++; $display("FAIL out_of_range[%0d] dut_b got %h expected %h", i, ob, eb); end
        end
    endtask

    task automatic test_saturation();
        step_t s[$];
        obs_t z = mk(0, 0, 0, 0, 0);
        obs_t ea, eb, oa, ob;
        s.push_back(mkstep(0, 1, 0, 0, 0, 0, B, mk(A, 1, 0, 0, 0), mk(A, 1, 0, 0, 0)));
        for (int k = 1; k <= 6; k++) begin
            s.push_back(mkstep(0, 0, 1, 0, 0, 0, B, mk(A, 1, 0, 0, 4'(k)),
                               mk(A, 1, 0, 0, (k > 3) ? 4'd3 : 4'(k))));
        end
        s.push_back(mkstep(0, 0, 0, 0, 0, 0, B, z, z));
        foreach (s[i]) begin
            drive(s[i]);
            cyc();
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = mk(a_data, a_valid, a_sel, a_err, a_cnt);
            ob = mk(b_data, b_valid, b_sel, b_err, {2'b00, b_cnt});
            vectors += 2;
            if (oa !== ea) begin miscompares++; $display("FAIL saturation[%0d] dut_a got %h expected %h", i, oa, ea); end
            if (ob !== eb) begin miscompares++; $display("FAIL saturation[%0d] dut_b got %h expected %h", i, ob, eb); end
        end
    endtask

    task automatic test_reset_mid_stall();
        step_t s[$];
        obs_t z = mk(0, 0, 0, 0, 0);
        obs_t ea, eb, oa, ob;
        s.push_back(mkstep(0, 1, 0, 0, 0, 2, B, mk(C, 1, 2, 0, 0), mk(C, 1, 2, 0, 0)));
        s.push_back(mkstep(0, 1, 1, 0, 0, 0, B, mk(C, 1, 2, 0, 1), mk(C, 1, 2, 0, 1)));
        s.push_back(mkstep(0, 1, 1, 0, 0, 0, B, mk(C, 1, 2, 0, 2), mk(C, 1, 2, 0, 2)));
        s.push_back(mkstep(1, 1, 1, 1, 0, 0, B, z, z));
        s.push_back(mkstep(0, 1, 0, 0, 0, 0, B, mk(A, 1, 0, 0, 0), mk(A, 1, 0, 0, 0)));
        foreach (s[i]) begin
            drive(s[i]);
            cyc();
            ea = qa.pop_front(); eb = qb.pop_front();
            oa = mk(a_data, a_valid, a_sel, a_err, a_cnt);
            ob = mk(b_data, b_valid, b_sel, b_err, {2'b00, b_cnt});
            vectors += 2;
            if (oa !== ea) begin miscompares++; $display("FAIL reset_mid_stall[%0d] dut_a got %h expected %h", i, oa, ea); end
            if (ob !== eb) begin miscompares++; $display("FAIL reset_mid_stall[%0d] dut_b got %h expected %h", i, ob, eb); end
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        stall    = 1'b0;
        refresh  = 1'b0;
        flush    = 1'b0;
        src_sel  = '0;
        src_data = {D, C, B, A};
        test_reset();
        test_load();
        test_stall_refresh();
        test_flush();
        test_out_of_range();
        test_saturation();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
